// File: rtl/aes_xts_out_sequencer_if.sv
// Handshake bundle between the AES core result port, the XTS output sequencer and the data-out sink.
interface aes_xts_out_sequencer_if #(
    parameter int unsigned DATA_W = 128
);
    logic              inCoreValid;
    logic [DATA_W-1:0] inCoreData;
    logic              outCoreReady;
    logic              outValid;
    logic [DATA_W-1:0] outData;
    logic [4:0]        outBytes;
    logic              outLast;
    logic              inReady;

    // Sequencer side
    modport slave (
        input  inCoreValid, inCoreData, inReady,
        output outCoreReady, outValid, outData, outBytes, outLast
    );

    // Core/sink side (environment)
    modport master (
        output inCoreValid, inCoreData, inReady,
        input  outCoreReady, outValid, outData, outBytes, outLast
    );
endinterface

// File: rtl/aes_xts_out_sequencer.sv
// AES-XTS output sequencer: counts the core blocks of one sector and swaps the last two
// blocks for ciphertext stealing, emitting the stolen block truncated to the tail length.
module aes_xts_out_sequencer #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             inClk,
    input  logic             inRstN,
    input  logic             inStart,
    input  logic [CNT_W-1:0] inNumBlocks,
    input  logic [3:0]       inTailBytes,
    output logic             outBusy,
    output logic             outErr,
    output logic             outDone,
    aes_xts_out_sequencer_if.slave bus
);
    localparam int unsigned BYTES_W    = 5;
    localparam int unsigned TAIL_W     = 4;
    localparam int unsigned FULL_BYTES = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        STREAM = 3'd1,
        HOLD   = 3'd2,
        TAIL   = 3'd3,
        DRAIN  = 3'd4
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_remain;
    logic [TAIL_W-1:0]   r_tail;
    logic [DATA_W-1:0]   r_pend;
    logic                r_valid;
    logic [DATA_W-1:0]   r_data;
    logic [BYTES_W-1:0]  r_bytes;
    logic                r_last;
    logic                r_busy;
    logic                r_err;
    logic                r_done;

    logic                w_out_free;
    logic                w_out_fire;
    logic                w_core_fire;
    logic                w_start_legal;
    logic [CNT_W-1:0]    w_remain_dec;
    logic [DATA_W-1:0]   w_tail_mask;

    assign w_out_free   = !r_valid || bus.inReady;
    assign w_out_fire   = r_valid && bus.inReady;
    assign bus.outCoreReady = ((r_state == STREAM) || (r_state == HOLD)) && w_out_free;
    assign w_core_fire  = bus.inCoreValid && bus.outCoreReady;

    // A tail needs at least two core blocks to steal from.
    assign w_start_legal = (r_state == IDLE) && (inNumBlocks != '0) &&
                           !((inTailBytes != '0) && (inNumBlocks < CNT_W'(2)));

    // Saturating decrement so a stray extra count can never wrap.
    assign w_remain_dec = (r_remain != '0) ? (r_remain - CNT_W'(1)) : '0;

    assign w_tail_mask  = (DATA_W'(1) << {r_tail, 3'b000}) - DATA_W'(1);

    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            r_state  <= IDLE;
            r_remain <= '0;
            r_tail   <= '0;
            r_pend   <= '0;
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_bytes  <= '0;
            r_last   <= 1'b0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_err  <= inStart && !w_start_legal;
            r_done <= 1'b0;
            if (w_out_fire) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (inStart && w_start_legal) begin
                        r_remain <= inNumBlocks;
                        r_tail   <= inTailBytes;
                        r_busy   <= 1'b1;
                        r_state  <= STREAM;
                    end
                end

                STREAM: begin
                    if (w_core_fire) begin
                        r_remain <= w_remain_dec;
                        if ((r_tail != '0) && (r_remain == CNT_W'(2))) begin
                            // Penultimate block is parked; it leaves last, truncated.
                            r_pend  <= bus.inCoreData;
                            r_state <= HOLD;
                        end else begin
                            r_valid <= 1'b1;
                            r_data  <= bus.inCoreData;
                            r_bytes <= BYTES_W'(FULL_BYTES);
                            r_last  <= (r_tail == '0) && (r_remain == CNT_W'(1));
                            if ((r_tail == '0) && (r_remain == CNT_W'(1))) begin
                                r_state <= DRAIN;
                            end
                        end
                    end
                end

                HOLD: begin
                    if (w_core_fire) begin
                        r_remain <= w_remain_dec;
                        r_valid  <= 1'b1;
                        r_data   <= bus.inCoreData;
                        r_bytes  <= BYTES_W'(FULL_BYTES);
                        r_last   <= 1'b0;
                        r_state  <= TAIL;
                    end
                end

                TAIL: begin
                    if (w_out_free) begin
                        r_valid <= 1'b1;
                        r_data  <= r_pend & w_tail_mask;
                        r_bytes <= BYTES_W'(r_tail);
                        r_last  <= 1'b1;
                        r_state <= DRAIN;
                    end
                end

                DRAIN: begin
                    if (w_out_fire && r_last) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.outValid = r_valid;
    assign bus.outData  = r_data;
    assign bus.outBytes = r_bytes;
    assign bus.outLast  = r_last;
    assign outBusy      = r_busy;
    assign outErr       = r_err;
    assign outDone      = r_done;
endmodule

// File: tb/tb_aes_xts_out_sequencer.sv
// Scoreboard bench for aes_xts_out_sequencer: random sectors against a block-list reference model.
module tb_aes_xts_out_sequencer;
    localparam int unsigned DATA_W = 128;
    localparam int unsigned CNT_W  = 16;

    typedef struct {
        logic [127:0] data;
        logic [4:0]   bytes;
        logic         last;
    } beat_t;

    logic             inClk = 1'b0;
    logic             inRstN = 1'b0;
    logic             inStart = 1'b0;
    logic [CNT_W-1:0] inNumBlocks = '0;
    logic [3:0]       inTailBytes = '0;
    logic             outBusy;
    logic             outErr;
    logic             outDone;

    aes_xts_out_sequencer_if #(.DATA_W(DATA_W)) bus();

    aes_xts_out_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .inClk       (inClk),
        .inRstN      (inRstN),
        .inStart     (inStart),
        .inNumBlocks (inNumBlocks),
        .inTailBytes (inTailBytes),
        .outBusy     (outBusy),
        .outErr      (outErr),
        .outDone     (outDone),
        .bus         (bus)
    );

    always #5 inClk = ~inClk;

    beat_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    rdy_mode = 0;
    int    stall_cnt = 0;
    bit    exp_done = 1'b0;
    bit    prev_stall = 1'b0;
    beat_t prev_beat;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    // Sink readiness: always, random, or four stall cycles per beat.
    always @(posedge inClk) begin
        #1;
        case (rdy_mode)
            0: bus.inReady = 1'b1;
            1: bus.inReady = (($urandom % 4) != 0);
            default: begin
                if (bus.outValid && stall_cnt < 4) begin
                    bus.inReady = 1'b0;
                    stall_cnt++;
                end else begin
                    bus.inReady = 1'b1;
                    if (bus.outValid) stall_cnt = 0;
                end
            end
        endcase
    end

    // Monitor: pops the scoreboard on each accepted beat, checks stability and done pulses.
    always @(negedge inClk) begin
        if (!inRstN) begin
            prev_stall = 1'b0;
            exp_done   = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 128'(bus.outValid), 128'(1));
                chk("hold_data", bus.outData, prev_beat.data);
                chk("hold_bytes", 128'(bus.outBytes), 128'(prev_beat.bytes));
                chk("hold_last", 128'(bus.outLast), 128'(prev_beat.last));
            end
            if (exp_done || outDone) begin
                chk("done_pulse", 128'(outDone), 128'(exp_done));
                if (exp_done) chk("busy_at_done", 128'(outBusy), 128'(0));
            end
            exp_done = 1'b0;
            if (bus.outValid && !bus.inReady) begin
                chk("core_stall", 128'(bus.outCoreReady), 128'(0));
                prev_stall = 1'b1;
                prev_beat.data  = bus.outData;
                prev_beat.bytes = bus.outBytes;
                prev_beat.last  = bus.outLast;
            end else begin
                prev_stall = 1'b0;
            end
            if (bus.outValid && bus.inReady) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_beat actual=%h required=none", bus.outData);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_data", bus.outData, e.data);
                    chk("beat_bytes", 128'(bus.outBytes), 128'(e.bytes));
                    chk("beat_last", 128'(bus.outLast), 128'(e.last));
                    if (e.last) exp_done = 1'b1;
                end
            end
        end
    end

    // Reference model: ciphertext stealing swaps the last two blocks and truncates the stolen one.
    task automatic model(input logic [127:0] blk[$], input int tail);
        int    n;
        beat_t b;
        n = blk.size();
        if (tail == 0) begin
            for (int i = 0; i < n; i++) begin
                b.data = blk[i]; b.bytes = 5'd16; b.last = (i == n - 1);
                exp_q.push_back(b);
            end
        end else begin
            for (int i = 0; i < n - 2; i++) begin
                b.data = blk[i]; b.bytes = 5'd16; b.last = 1'b0;
                exp_q.push_back(b);
            end
            b.data = blk[n-1]; b.bytes = 5'd16; b.last = 1'b0;
            exp_q.push_back(b);
            b.data = '0;
            for (int k = 0; k < tail; k++) b.data[8*k +: 8] = blk[n-2][8*k +: 8];
            b.bytes = 5'(tail); b.last = 1'b1;
            exp_q.push_back(b);
        end
    endtask

    task automatic pulse_start(input int n, input int t, input bit exp_err, input bit exp_busy);
        @(posedge inClk); #1;
        inStart = 1'b1; inNumBlocks = CNT_W'(n); inTailBytes = 4'(t);
        @(posedge inClk); #1;
        inStart = 1'b0;
        @(negedge inClk);
        chk("start_err", 128'(outErr), 128'(exp_err));
        chk("start_busy", 128'(outBusy), 128'(exp_busy));
    endtask

    task automatic send_blocks(input logic [127:0] blk[$], input int count);
        int t;
        @(posedge inClk); #1;
        for (int i = 0; i < count; i++) begin
            bus.inCoreValid = 1'b1;
            bus.inCoreData  = blk[i];
            t = 0;
            @(negedge inClk);
            while (!bus.outCoreReady && t < 300) begin
                t++;
                @(negedge inClk);
            end
            if (!bus.outCoreReady) begin
                n_tests++;
                n_fail++;
                $display("FAIL core_accept_timeout actual=not_ready required=ready block=%0d", i);
                bus.inCoreValid = 1'b0;
                return;
            end
            @(posedge inClk); #1;
            bus.inCoreValid = 1'b0;
            if (($urandom % 3) == 0) begin
                @(posedge inClk); #1;
            end
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (outBusy && t < 600) begin
            t++;
            @(negedge inClk);
        end
        repeat (2) @(negedge inClk);
        chk("idle_reached", 128'(outBusy), 128'(0));
        chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    endtask

    task automatic run_sector(input int n, input int tail);
        logic [127:0] blk[$];
        for (int i = 0; i < n; i++) blk.push_back({$urandom, $urandom, $urandom, $urandom});
        model(blk, tail);
        pulse_start(n, tail, 1'b0, 1'b1);
        send_blocks(blk, n);
        wait_idle();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] blk[$];
        int n;
        int t;

        // Reset with core data already offered
        bus.inCoreValid = 1'b1;
        bus.inCoreData  = {4{32'hdeadbeef}};
        bus.inReady     = 1'b1;
        inRstN = 1'b0;
        repeat (3) @(negedge inClk);
        chk("rst_valid", 128'(bus.outValid), 128'(0));
        chk("rst_core_ready", 128'(bus.outCoreReady), 128'(0));
        chk("rst_data", bus.outData, 128'(0));
        chk("rst_bytes", 128'(bus.outBytes), 128'(0));
        chk("rst_last", 128'(bus.outLast), 128'(0));
        chk("rst_busy", 128'(outBusy), 128'(0));
        @(posedge inClk); #1;
        inRstN = 1'b1;
        @(negedge inClk);
        chk("idle_core_ready", 128'(bus.outCoreReady), 128'(0));
        @(posedge inClk); #1;
        bus.inCoreValid = 1'b0;

        // Plain and stolen sectors, then the stolen one under heavy backpressure
        rdy_mode = 0;
        run_sector(3, 0);
        run_sector(3, 5);
        rdy_mode = 2;
        run_sector(3, 5);
        rdy_mode = 0;

        // Illegal starts
        pulse_start(1, 3, 1'b1, 1'b0);
        pulse_start(0, 0, 1'b1, 1'b0);
        fork
            run_sector(5, 0);
            begin
                repeat (4) @(posedge inClk);
                pulse_start(2, 0, 1'b1, 1'b1);
            end
        join

        // Reset while the penultimate block is parked
        rdy_mode = 1;
        blk.delete();
        for (int i = 0; i < 4; i++) blk.push_back({$urandom, $urandom, $urandom, $urandom});
        model(blk, 7);
        pulse_start(4, 7, 1'b0, 1'b1);
        send_blocks(blk, 3);
        repeat (2) @(posedge inClk);
        #1;
        inRstN = 1'b0;
        exp_q.delete();
        @(negedge inClk);
        chk("midrst_valid", 128'(bus.outValid), 128'(0));
        chk("midrst_busy", 128'(outBusy), 128'(0));
        chk("midrst_data", bus.outData, 128'(0));
        chk("midrst_last", 128'(bus.outLast), 128'(0));
        @(posedge inClk); #1;
        inRstN = 1'b1;
        run_sector(2, 9);

        // Random sectors
        for (int s = 0; s < 25; s++) begin
            rdy_mode = (($urandom % 4) == 0) ? 2 : 1;
            n = 1 + int'($urandom % 6);
            t = int'($urandom % 16);
            if (n < 2) t = 0;
            run_sector(n, t);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
